issue_scheduler: RTL and testbench
==================================

# issue_scheduler

Issue scheduler for the 5-stage MIPS pipeline. It sits between the instruction source and the CPU's `i_datain` port. It tracks in-flight register writes in a per-register scoreboard and holds back dependent instructions until the producer's result is architecturally visible. In their place it issues NOP bubbles (all-zero words), and it inserts a fixed branch shadow after `beq`/`bne`/`j`. This removes the hand-inserted NOP padding from programs.

## Interface
Parameters:
- `WB_LAT`, default 4: bubbles required between a register producer and its first consumer; legal range 1..7.
- `BR_BUBBLES`, default 3: bubbles issued after any `beq`/`bne`/`j`; legal range 0..7.

Ports:
- `clock`, input, 1: single clock, rising edge.
- `start`, input, 1: asynchronous, active-low reset; low clears all state.
- `in_valid`, input, 1: `in_instr` holds an instruction to issue.
- `in_instr`, input, 32: candidate instruction word.
- `in_ready`, output, 1: combinational; the instruction is accepted this cycle when `in_valid` and `in_ready` are both high.
- `issue_instr`, output, 32: registered word driven to the CPU's `i_datain`; 0 when bubbling.
- `issue_valid`, output, 1: registered; `issue_instr` is a real accepted instruction.
- `stall_cnt`, output, 16: saturating count of cycles with `in_valid`=1 and `in_ready`=0.

## Operation
Decode of `in_instr` (op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0]):
- op 000000 with funct 000000/000010/000011 (sll/srl/sra): reads rt, writes rd.
- op 000000, any other funct: reads rs and rt, writes rd.
- 100011 (lw): reads rs, writes rt.
- 001000/001001/001100/001101 (addi/addiu/andi/ori): reads rs, writes rt.
- 101011 (sw): reads rs and rt; no write.
- 000100/000101 (beq/bne): reads rs and rt; no write; branch.
- 000010 (j): no reads, no write; branch.
- Any other opcode: no reads, no write; issued unchanged.
- Register 0 is never a hazard source and is never recorded as a destination. The all-zero NOP therefore issues freely.

Scoreboard:
- `pend[r]` is a 3-bit down-counter for each of registers 1..31.
- Hazard: any read register r≠0 has `pend[r]`≠0.
- On acceptance of a writer with destination d≠0, `pend[d]` loads `WB_LAT`.
- All other nonzero entries decrement by 1 every cycle.
- If a load and a decrement target the same entry in the same cycle, the load wins.

State machine:
- ISSUE:
  - `in_ready` = !hazard.
  - On acceptance: `issue_instr`←`in_instr` and `issue_valid`←1.
  - Otherwise: `issue_instr`←0 and `issue_valid`←0.
  - Accepting a branch with `BR_BUBBLES`>0 moves to SHADOW with `sh_cnt`←`BR_BUBBLES`.
- SHADOW:
  - `in_ready`=0; a bubble issues each cycle.
  - `sh_cnt` decrements each cycle; the state returns to ISSUE when `sh_cnt` goes 1→0.
  - The scoreboard keeps decrementing during SHADOW.
- `stall_cnt` increments whenever `in_valid`=1 and `in_ready`=0, in both states. It saturates at 0xFFFF.

## Timing
- Reset values, while `start`=0, asynchronous: state=ISSUE, all `pend`=0, `sh_cnt`=0, `issue_instr`=0, `issue_valid`=0, `stall_cnt`=0. `in_ready` then equals 1.
- Issue latency: an instruction accepted at edge N appears on `issue_instr` from edge N until edge N+1.
- RAW spacing: if a producer is accepted at edge N, the earliest dependent acceptance is edge N+`WB_LAT`+1. This gives exactly `WB_LAT` bubbles between them.
- Independent instructions issue back-to-back at 1 per cycle.
- Branch: if a branch is accepted at edge N, the next acceptance is edge N+`BR_BUBBLES`+1.
- Reset asserted mid-stall or mid-shadow discards all pending state. The first cycle after release accepts any instruction.
- A hazard and a branch on the same word: the hazard stalls first; the shadow starts only after acceptance.

## Test plan
- **Reset:** hold `start`=0 with `in_valid`=1. Required: `issue_instr`=0, `issue_valid`=0, `stall_cnt`=0, `in_ready`=1. Release reset, then a NOP issues on the next edge.
- **RAW (I-type to R-type):** lw gr1 ({100011,gr0,gr1,0x0001}), then add gr3=gr1+gr2 immediately valid. Required: 4 bubbles, then the add issues 5 edges after the lw; `stall_cnt`=4.
- **Independent stream:** lw gr1, then lw gr2, then ori gr4=gr5|2. Required: all three issue on consecutive edges, `stall_cnt`=0.
- **Branch shadow:** beq gr1,gr2,0x200, then bne. Required: 3 bubbles after beq, then bne issues, followed by 3 more bubbles.
- **Shift and register 0:**
  - sll gr2=gr3<<1 issued 1 cycle after a writer of gr1 with rs=gr1: no stall, because sll ignores rs.
  - add gr3=gr0+gr0 after a write to gr0: no stall.
- **Reset mid-stall and saturation:**
  - Assert `start`=0 during a RAW stall, then release. Required: the dependent instruction issues on the first edge.
  - Force 70000 stall cycles. Required: `stall_cnt`=0xFFFF.

Source files
------------

// File: rtl/issue_scheduler.sv
// Issue scheduler: holds back RAW-dependent words with a per-register
// countdown scoreboard and pads a fixed bubble shadow after branches.
module issue_scheduler #(
  parameter int unsigned WB_LAT     = 4,
  parameter int unsigned BR_BUBBLES = 3
) (
  input  logic        clock,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [31:0] issue_instr,
  output logic        issue_valid,
  output logic [15:0] stall_cnt
);

  localparam logic [2:0] LAT = 3'(WB_LAT);
  localparam logic [2:0] BRB = 3'(BR_BUBBLES);

  typedef enum logic {
    S_ISSUE,
    S_SHADOW
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0][2:0] pend;
  logic [2:0]       sh_cnt;

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       is_shift;

  logic       use_rs;
  logic       use_rt;
  logic       wr_en;
  logic       is_br;
  logic [4:0] dst;
  logic       hazard;
  logic       accept;

  assign op    = in_instr[31:26];
  assign rs    = in_instr[25:21];
  assign rt    = in_instr[20:16];
  assign rd    = in_instr[15:11];
  assign funct = in_instr[5:0];

  assign is_shift = (op == 6'b000000) &&
                    ((funct == 6'b000000) ||
                     (funct == 6'b000010) ||
                     (funct == 6'b000011));

  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    wr_en  = 1'b0;
    is_br  = 1'b0;
    dst    = 5'd0;
    unique case (1'b1)
      is_shift: begin
        use_rt = 1'b1;
        wr_en  = 1'b1;
        dst    = rd;
      end
      (op == 6'b000000) && !is_shift: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        wr_en  = 1'b1;
        dst    = rd;
      end
      (op == 6'b100011),
      (op == 6'b001000),
      (op == 6'b001001),
      (op == 6'b001100),
      (op == 6'b001101): begin
        use_rs = 1'b1;
        wr_en  = 1'b1;
        dst    = rt;
      end
      (op == 6'b101011): begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      (op == 6'b000100),
      (op == 6'b000101): begin
        use_rs = 1'b1;
        use_rt = 1'b1;
        is_br  = 1'b1;
      end
      (op == 6'b000010): begin
        is_br = 1'b1;
      end
      default: ;
    endcase
  end

  // pend[0] stays zero, so gr0 never raises a hazard
  assign hazard = (use_rs && (rs != 5'd0) && (pend[rs] != 3'd0)) ||
                  (use_rt && (rt != 5'd0) && (pend[rt] != 3'd0));

  always_ff @(posedge clock or negedge start) begin
    if (!start) state <= S_ISSUE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_ISSUE: begin
        if (accept && is_br && (BRB != 3'd0))
          state_nx = S_SHADOW;
      end
      S_SHADOW: begin
        if (sh_cnt <= 3'd1)
          state_nx = S_ISSUE;
      end
      default: state_nx = S_ISSUE;
    endcase
  end

  always_comb begin
    in_ready = (state == S_ISSUE) && !hazard;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      sh_cnt <= 3'd0;
    end else if (state == S_ISSUE) begin
      if (accept && is_br) sh_cnt <= BRB;
    end else if (sh_cnt != 3'd0) begin
      sh_cnt <= sh_cnt - 3'd1;
    end
  end

  // a fresh load beats the per-cycle decrement
  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      pend <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (accept && wr_en && (dst == 5'(r)))
          pend[r] <= LAT;
        else if (pend[r] != 3'd0)
          pend[r] <= pend[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      issue_instr <= 32'd0;
      issue_valid <= 1'b0;
    end else begin
      issue_instr <= accept ? in_instr : 32'd0;
      issue_valid <= accept;
    end
  end

  always_ff @(posedge clock or negedge start) begin
    if (!start) begin
      stall_cnt <= 16'd0;
    end else if (in_valid && !in_ready &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: vector table plus
// hand-written reset, shadow and saturation sequences.
module tb_issue_scheduler;

  localparam logic [31:0] LW1   = 32'h8C010001;
  localparam logic [31:0] LW2   = 32'h8C020001;
  localparam logic [31:0] ADD   = 32'h00221820;
  localparam logic [31:0] ORI   = 32'h34A40002;
  localparam logic [31:0] BEQ   = 32'h10220200;
  localparam logic [31:0] BNE   = 32'h14640010;
  localparam logic [31:0] SLL   = 32'h00231040;
  localparam logic [31:0] ADDI0 = 32'h20A00001;
  localparam logic [31:0] ADD00 = 32'h00001820;
  localparam logic [31:0] ODD   = 32'hFFFFFFFF;
  localparam logic [31:0] ADD11 = 32'h00210820;

  logic        clock = 1'b0;
  logic        start;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic [15:0] stall_cnt;

  logic        start2;
  logic        in_valid2;
  logic [31:0] in_instr2;
  logic        in_ready2;
  logic [31:0] issue_instr2;
  logic        issue_valid2;
  logic [15:0] stall_cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  issue_scheduler dut (
    .clock       (clock),
    .start       (start),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .issue_instr (issue_instr),
    .issue_valid (issue_valid),
    .stall_cnt   (stall_cnt)
  );

  issue_scheduler #(.WB_LAT(7), .BR_BUBBLES(0)) dut2 (
    .clock       (clock),
    .start       (start2),
    .in_valid    (in_valid2),
    .in_instr    (in_instr2),
    .in_ready    (in_ready2),
    .issue_instr (issue_instr2),
    .issue_valid (issue_valid2),
    .stall_cnt   (stall_cnt2)
  );

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        rdy;
    logic [31:0] iss;
    logic        iv;
    logic [15:0] st;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic row(input logic v, input logic [31:0] i,
                     input logic r, input logic [31:0] s,
                     input logic iv, input logic [15:0] st);
    vec_t e;
    e.v = v; e.instr = i; e.rdy = r;
    e.iss = s; e.iv = iv; e.st = st;
    tbl.push_back(e);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // RAW lw -> add
    row(1, LW1, 1, LW1, 1, 0);
    row(1, ADD, 0, 0, 0, 1);
    row(1, ADD, 0, 0, 0, 2);
    row(1, ADD, 0, 0, 0, 3);
    row(1, ADD, 0, 0, 0, 4);
    row(1, ADD, 1, ADD, 1, 4);
    // independent stream
    row(1, LW1, 1, LW1, 1, 4);
    row(1, LW2, 1, LW2, 1, 4);
    row(1, ORI, 1, ORI, 1, 4);
    repeat (4) row(0, 0, 1, 0, 0, 4);
    // branch shadows
    row(1, BEQ, 1, BEQ, 1, 4);
    row(1, BNE, 0, 0, 0, 5);
    row(1, BNE, 0, 0, 0, 6);
    row(1, BNE, 0, 0, 0, 7);
    row(1, BNE, 1, BNE, 1, 7);
    repeat (3) row(0, 0, 0, 0, 0, 7);
    row(0, 0, 1, 0, 0, 7);
    // shift ignores rs, gr0 never hazards
    row(1, LW1, 1, LW1, 1, 7);
    row(1, SLL, 1, SLL, 1, 7);
    row(1, ADDI0, 1, ADDI0, 1, 7);
    row(1, ADD00, 1, ADD00, 1, 7);
    // hazard on a branch stalls before the shadow
    row(1, BEQ, 0, 0, 0, 8);
    row(1, BEQ, 0, 0, 0, 9);
    row(1, BEQ, 1, BEQ, 1, 9);
    row(1, BEQ, 0, 0, 0, 10);
    row(1, BEQ, 0, 0, 0, 11);
    row(1, BEQ, 0, 0, 0, 12);
    row(0, 0, 1, 0, 0, 12);
    row(1, ODD, 1, ODD, 1, 12);

    start = 1'b0; in_valid = 1'b1; in_instr = 32'd0;
    start2 = 1'b0; in_valid2 = 1'b1; in_instr2 = ADD11;

    repeat (2) tick();
    chk("rst_issue_instr", issue_instr, 32'd0);
    chk("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    start = 1'b1;
    tick();
    chk("nop_issue_valid", {31'd0, issue_valid}, 32'd1);
    chk("nop_issue_instr", issue_instr, 32'd0);

    for (int k = 0; k < tbl.size(); k++) begin
      in_valid = tbl[k].v;
      in_instr = tbl[k].instr;
      #1;
      chk($sformatf("v%0d_ready", k),
          {31'd0, in_ready}, {31'd0, tbl[k].rdy});
      tick();
      chk($sformatf("v%0d_issue", k), issue_instr, tbl[k].iss);
      chk($sformatf("v%0d_ivalid", k),
          {31'd0, issue_valid}, {31'd0, tbl[k].iv});
      chk($sformatf("v%0d_stall", k),
          {16'd0, stall_cnt}, {16'd0, tbl[k].st});
    end

    // reset during a RAW stall
    in_valid = 1'b1; in_instr = LW1;
    tick();
    in_instr = ADD;
    tick();
    tick();
    chk("ms_pre_stall", {16'd0, stall_cnt}, 32'd14);
    #2 start = 1'b0;
    #1;
    chk("ms_async_ivalid", {31'd0, issue_valid}, 32'd0);
    chk("ms_async_stall", {16'd0, stall_cnt}, 32'd0);
    chk("ms_ready", {31'd0, in_ready}, 32'd1);
    tick();
    start = 1'b1;
    #1;
    chk("ms_rel_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("ms_issue", issue_instr, ADD);
    chk("ms_ivalid", {31'd0, issue_valid}, 32'd1);

    // reset during a branch shadow
    in_instr = BEQ;
    tick();
    chk("sh_beq", issue_instr, BEQ);
    in_instr = BNE;
    tick();
    chk("sh_stall", {16'd0, stall_cnt}, 32'd1);
    #2 start = 1'b0;
    #1;
    chk("sh_async_stall", {16'd0, stall_cnt}, 32'd0);
    tick();
    start = 1'b1;
    #1;
    chk("sh_rel_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("sh_issue", issue_instr, BNE);
    chk("sh_ivalid", {31'd0, issue_valid}, 32'd1);

    // saturation on the WB_LAT=7 instance
    chk("sat_rst_ready", {31'd0, in_ready2}, 32'd1);
    start2 = 1'b1;
    repeat (16) tick();
    chk("sat_early", {16'd0, stall_cnt2}, 32'd14);
    tick();
    chk("sat_reissue", issue_instr2, ADD11);
    chk("sat_reissue_v", {31'd0, issue_valid2}, 32'd1);
    repeat (75500) tick();
    chk("sat_stall", {16'd0, stall_cnt2}, 32'h0000FFFF);
    tick();
    chk("sat_hold", {16'd0, stall_cnt2}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
